// File: rtl/char_input_ctrl.sv
// char_input_ctrl
//   Turns three raw, bouncing keys into clean character controls.
//   Every key is synchronized and then debounced on frame boundaries.
//   The two direction keys are resolved to a single move request.
//   The shoot key drives a one-shot FSM that has a cooldown and only
//   re-arms after the key is released.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-high
//   startOfFrame one-clk pulse per frame; the debounce and cooldown time base
//   leftKey      raw left key level (async)
//   rightKey     raw right key level (async)
//   shootKey     raw shoot key level (async)
//   shotActive   a player shot is on screen; blocks only new shots from IDLE
//   leftPress    registered move-left request
//   rightPress   registered move-right request (never high together with left)
//   shootPulse   registered one-clk shot request
//   facing       registered facing direction, 1 = right, 0 = left
module char_input_ctrl #(
    parameter int DEBOUNCE_FRAMES      = 2,
    parameter int SHOT_COOLDOWN_FRAMES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic leftKey,
    input  logic rightKey,
    input  logic shootKey,
    input  logic shotActive,
    output logic leftPress,
    output logic rightPress,
    output logic shootPulse,
    output logic facing
);

    localparam int KEY_L = 0;
    localparam int KEY_R = 1;
    localparam int KEY_S = 2;

    // The counter never holds DEBOUNCE_FRAMES. Reaching it is the toggle event.
    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_FRAMES - 1);
    localparam logic [7:0] CD_LOAD  = 8'(SHOT_COOLDOWN_FRAMES);

    typedef enum logic [1:0] {LAST_NONE, LAST_LEFT, LAST_RIGHT, LAST_TIE} last_t;
    typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN, WAIT_RELEASE} shoot_state_t;

    logic [2:0]      sync1, sync2;
    logic [2:0]      deb, deb_nxt;
    logic [2:0][3:0] cnt, cnt_nxt;
    logic [2:0]      rise;
    last_t           last, last_nxt;
    logic            left_nxt, right_nxt, facing_nxt;
    shoot_state_t    state, state_nxt;
    logic [7:0]      cd_cnt, cd_nxt;

    // ---------------- synchronizers + debounce ----------------
    always_comb begin
        deb_nxt = deb;
        cnt_nxt = cnt;
        if (startOfFrame) begin
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == deb[k]) begin
                    cnt_nxt[k] = '0;
                end else if (cnt[k] == CNT_LAST) begin
                    deb_nxt[k] = ~deb[k];
                    cnt_nxt[k] = '0;
                end else begin
                    cnt_nxt[k] = cnt[k] + 4'd1;
                end
            end
        end
    end

    // ---------------- direction arbitration ----------------
    // Rising edges are taken from the debounced next state, so last-pressed
    // moves on the same edge as the debounced key it describes.
    assign rise = deb_nxt & ~deb;

    always_comb begin
        last_nxt = last;
        if (rise[KEY_L] && rise[KEY_R]) last_nxt = LAST_TIE;
        else if (rise[KEY_L])           last_nxt = LAST_LEFT;
        else if (rise[KEY_R])           last_nxt = LAST_RIGHT;
    end

    // The requests come from the registered debounced state. They therefore
    // follow a debounced change by one clk. With both keys held, a tie gives
    // no request until one key is released.
    always_comb begin
        left_nxt  = 1'b0;
        right_nxt = 1'b0;
        case ({deb[KEY_R], deb[KEY_L]})
            2'b01:   left_nxt  = 1'b1;
            2'b10:   right_nxt = 1'b1;
            2'b11: begin
                left_nxt  = (last == LAST_LEFT);
                right_nxt = (last == LAST_RIGHT);
            end
            default: ;
        endcase
        // Facing is derived from the same next values, so it changes in the
        // same clk as the request that causes it.
        facing_nxt = facing;
        if (right_nxt)     facing_nxt = 1'b1;
        else if (left_nxt) facing_nxt = 1'b0;
    end

    // ---------------- shoot FSM ----------------
    always_comb begin
        state_nxt = state;
        cd_nxt    = cd_cnt;
        case (state)
            IDLE: begin
                if (startOfFrame && deb[KEY_S] && !shotActive) state_nxt = FIRE;
            end
            FIRE: begin
                state_nxt = COOLDOWN;
                cd_nxt    = CD_LOAD;
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    // The exit frame is the one that takes the counter to 0.
                    // The <= 1 test also keeps the counter from wrapping.
                    if (cd_cnt <= 8'd1) begin
                        cd_nxt    = '0;
                        state_nxt = deb[KEY_S] ? WAIT_RELEASE : IDLE;
                    end else begin
                        cd_nxt = cd_cnt - 8'd1;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!deb[KEY_S]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            cnt        <= '0;
            last       <= LAST_NONE;
            state      <= IDLE;
            cd_cnt     <= '0;
            leftPress  <= 1'b0;
            rightPress <= 1'b0;
            shootPulse <= 1'b0;
            facing     <= 1'b1;
        end else begin
            sync1      <= {shootKey, rightKey, leftKey};
            sync2      <= sync1;
            deb        <= deb_nxt;
            cnt        <= cnt_nxt;
            last       <= last_nxt;
            state      <= state_nxt;
            cd_cnt     <= cd_nxt;
            leftPress  <= left_nxt;
            rightPress <= right_nxt;
            shootPulse <= (state == FIRE);
            facing     <= facing_nxt;
        end
    end

endmodule

// File: tb/tb_char_input_ctrl.sv
// Testbench for char_input_ctrl.
// The stimulus pushes the expected output tuple {leftPress, rightPress,
// shootPulse, facing} and the clk index at which it must appear. The monitor
// compares every change of that tuple against the head of the queue.
module tb_char_input_ctrl;

    logic clk = 1'b0;
    logic reset, startOfFrame, leftKey, rightKey, shootKey, shotActive;
    logic leftPress, rightPress, shootPulse, facing;

    char_input_ctrl #(.DEBOUNCE_FRAMES(2), .SHOT_COOLDOWN_FRAMES(15)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .leftKey(leftKey), .rightKey(rightKey), .shootKey(shootKey),
        .shotActive(shotActive), .leftPress(leftPress), .rightPress(rightPress),
        .shootPulse(shootPulse), .facing(facing)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] exp_val[$];
    int         exp_cyc[$];
    string      exp_name[$];

    int n_checks = 0;
    int n_fail   = 0;
    int last_sof = 0;
    int sof_cnt  = 0;
    int k2, k3;
    bit mon_en   = 0;
    bit started  = 0;
    bit end_req  = 0;
    bit end_done = 0;
    logic [3:0] prev;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [3:0] cur;
        logic [3:0] ev;
        int         ec;
        string      en;
        cur = {leftPress, rightPress, shootPulse, facing};
        if (mon_en && !end_done) begin
            if (!started || cur != prev) begin
                started = 1;
                n_checks++;
                if (exp_val.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected: got %b @%0d, required no change", cur, cyc);
                end else begin
                    ev = exp_val.pop_front();
                    ec = exp_cyc.pop_front();
                    en = exp_name.pop_front();
                    if (cur != ev || cyc != ec) begin
                        n_fail++;
                        $display("FAIL %s: got %b @%0d, required %b @%0d", en, cur, cyc, ev, ec);
                    end
                end
            end
            prev = cur;
            if (end_req) begin
                n_checks++;
                if (exp_val.size() != 0) begin
                    n_fail++;
                    $display("FAIL missing: %0d events never seen, first %s required %b @%0d",
                             exp_val.size(), exp_name[0], exp_val[0], exp_cyc[0]);
                end
                end_done = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Three quiet clks, then one startOfFrame clk. last_sof is the edge at
    // which that pulse is sampled.
    task automatic frame();
        repeat (3) step();
        startOfFrame = 1'b1;
        last_sof = cyc + 1;
        sof_cnt++;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic push(input string name, input logic [3:0] v, input int c);
        exp_name.push_back(name);
        exp_val.push_back(v);
        exp_cyc.push_back(c);
    endtask

    // A shot fires on the startOfFrame at last_sof, so the pulse is one clk wide.
    task automatic push_pulse(input string name);
        push(name, 4'b0011, last_sof + 1);
        push({name, "_end"}, 4'b0001, last_sof + 2);
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0;
        leftKey = 1'b0; rightKey = 1'b0; shootKey = 1'b0; shotActive = 1'b0;
        repeat (3) step();
        push("reset", 4'b0001, cyc);
        mon_en = 1;

        // Right held from reset release.
        reset = 1'b0; rightKey = 1'b1;
        frame(); frame();
        push("right_hold", 4'b0101, last_sof + 1);

        // Left pressed over a held right wins, then released.
        leftKey = 1'b1; frame(); frame();
        push("left_over_right", 4'b1000, last_sof + 1);
        leftKey = 1'b0; frame(); frame();
        push("left_release", 4'b0101, last_sof + 1);

        // Left glitch across a single frame sample: no change expected.
        leftKey = 1'b1; frame();
        leftKey = 1'b0; frame(); frame();

        // Release right.
        rightKey = 1'b0; frame(); frame();
        push("right_release", 4'b0001, last_sof + 1);

        // Both rising on the same frame: no request until one is released.
        leftKey = 1'b1; rightKey = 1'b1; frame(); frame(); frame();
        leftKey = 1'b0; frame(); frame();
        push("tie_left_release", 4'b0101, last_sof + 1);
        rightKey = 1'b0; frame(); frame();
        push("tie_right_release", 4'b0001, last_sof + 1);

        // Left first, then right later: right wins.
        leftKey = 1'b1; frame(); frame();
        push("left_only", 4'b1000, last_sof + 1);
        rightKey = 1'b1; frame(); frame();
        push("right_later", 4'b0101, last_sof + 1);
        leftKey = 1'b0; rightKey = 1'b0; frame(); frame();
        push("both_release", 4'b0001, last_sof + 1);

        // Shoot held: one pulse, then nothing while held.
        shootKey = 1'b1; frame(); frame(); frame();
        push_pulse("shot1");
        repeat (18) frame();
        shootKey = 1'b0; frame(); frame();

        // Second press after release fires again.
        shootKey = 1'b1; frame(); frame(); frame();
        push_pulse("shot2");
        k2 = sof_cnt;
        // Release, then press again so the debounced key rises one frame
        // before cooldown ends. The exit must go to WAIT_RELEASE, with no shot.
        shootKey = 1'b0;
        while (sof_cnt < k2 + 12) frame();
        shootKey = 1'b1;
        while (sof_cnt < k2 + 20) frame();
        shootKey = 1'b0; frame(); frame();

        // shotActive blocks the shot. Dropping it fires on the next frame.
        shotActive = 1'b1; shootKey = 1'b1;
        repeat (4) frame();
        shotActive = 1'b0; frame();
        push_pulse("shot_after_active");
        k3 = sof_cnt;

        // In cooldown: press left and raise shotActive, then reset at count 7.
        leftKey = 1'b1; shootKey = 1'b0; shotActive = 1'b1;
        frame(); frame();
        push("left_in_cooldown", 4'b1000, last_sof + 1);
        while (sof_cnt < k3 + 8) frame();
        reset = 1'b1; leftKey = 1'b0; shotActive = 1'b0;
        push("mid_reset", 4'b0001, cyc + 1);
        step();
        reset = 1'b0;

        // After the reset the FSM is IDLE, so a fresh press fires immediately.
        shootKey = 1'b1; frame(); frame(); frame();
        push_pulse("shot_post_reset");
        shootKey = 1'b0;
        repeat (3) frame();

        end_req = 1;
        wait (end_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_input_ctrl.md
CHAR_INPUT_CTRL -- requirements
Module: char_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 2: consecutive startOfFrame samples needed to change a debounced key state; legal range 1..15.
REQ-002 Parameter SHOT_COOLDOWN_FRAMES, default 15: frames after a shot during which no new shot is issued; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 startOfFrame  input  1  one-clk pulse at each frame start.
REQ-006 leftKey  input  1  raw left key level, asynchronous to clk, bounces.
REQ-007 rightKey  input  1  raw right key level, asynchronous to clk, bounces.
REQ-008 shootKey  input  1  raw shoot key level, asynchronous to clk, bounces.
REQ-009 shotActive  input  1  high while a player shot exists on screen.
REQ-010 leftPress  output  1  registered move-left request to the character mover.
REQ-011 rightPress  output  1  registered move-right request to the character mover.
REQ-012 shootPulse  output  1  registered one-clk shot request.
REQ-013 facing  output  1  registered facing direction: 1 right, 0 left.

Function
REQ-014 Each raw key shall pass through a 2-flop synchronizer (reset value 0) before any other use.
REQ-015 Debounce shall be per key and shall run only on startOfFrame cycles: synced value equal to the debounced value clears that key's counter; a differing value increments the counter.
REQ-016 Debounced state shall toggle, and the counter shall clear, on the startOfFrame at which the counter would reach DEBOUNCE_FRAMES; the new state shall be visible the following clk.
REQ-017 A glitch shorter than DEBOUNCE_FRAMES consecutive frame samples shall never change the debounced state.
REQ-018 Direction: only debounced left pressed -> leftPress=1; only debounced right pressed -> rightPress=1; neither pressed -> both 0.
REQ-019 Both keys pressed: the key that became pressed later wins, tracked by a last-pressed register updated on debounced rising edges.
REQ-020 Both debounced keys rising on the same startOfFrame -> both outputs 0 until one key is released.
REQ-021 leftPress and rightPress shall never both be 1.
REQ-022 Direction outputs shall update one clk after a debounced-state change.
REQ-023 facing shall become 1 on any clk where rightPress=1 and 0 where leftPress=1; otherwise it holds.
REQ-024 Shoot FSM states: IDLE, FIRE, COOLDOWN, WAIT_RELEASE.
REQ-025 IDLE -> FIRE on startOfFrame when debounced shoot=1 and shotActive=0; otherwise stay in IDLE.
REQ-026 FIRE lasts exactly one clk; shootPulse=1 only in the clk after entry into FIRE; FIRE -> COOLDOWN with the cooldown counter loaded to SHOT_COOLDOWN_FRAMES.
REQ-027 COOLDOWN: the counter decrements on each startOfFrame.
REQ-028 COOLDOWN exit on the startOfFrame where the counter reaches 0: to WAIT_RELEASE if debounced shoot=1, else to IDLE.
REQ-029 WAIT_RELEASE -> IDLE when debounced shoot=0, so holding the key never auto-fires.
REQ-030 shotActive rising during COOLDOWN or WAIT_RELEASE shall have no effect on the FSM; it gates only the IDLE->FIRE transition.
REQ-031 The cooldown counter shall be 8 bits and shall not wrap below 0.

Reset
REQ-032 While reset=1 at a clk edge, the following shall clear: all synchronizer flops, debounced states, debounce counters, last-pressed register, cooldown counter, leftPress, rightPress and shootPulse; the FSM shall enter IDLE and facing shall be 1.
REQ-033 Reset asserted mid-operation (any FSM state, any counter value) shall take effect at the next clk edge and override startOfFrame and all key inputs.

Verification
REQ-034 Hold rightKey=1 from reset release -> rightPress=1 one clk after the 2nd startOfFrame that samples the synced 1; facing stays 1.
REQ-035 Pulse leftKey high across exactly 1 startOfFrame -> leftPress stays 0 throughout.
REQ-036 Right held and stable, then left pressed -> leftPress=1 and rightPress=0 after debounce, facing=0; release left -> rightPress=1 again after debounce.
REQ-037 Hold shootKey with shotActive=0 -> exactly one shootPulse of one clk, then none for 15+ frames while held; release, press again after cooldown -> a second pulse.
REQ-038 Debounced shoot=1 with shotActive=1 -> no pulse; drop shotActive -> pulse on the next startOfFrame, one clk later.
REQ-039 Assert reset during COOLDOWN with the counter at 7 -> next clk: FSM in IDLE, all outputs 0, facing=1.
